// File: rtl/jtframe_btn_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : jtframe_btn_decoder
// Purpose  : Turns a raw, bouncing, active-low button into a debounced level
//            plus one-cycle gesture strobes (short press, long press, double
//            click). Gesture timing is counted in video frames, one per
//            falling edge of LVBL, so the thresholds follow the refresh rate.
// Ports    : clk         - system clock
//            rst         - asynchronous active-high reset
//            LVBL        - vertical blank, active low, synchronous to clk
//            btn_n       - raw button, active low, asynchronous to clk
//            pressed     - debounced level, 1 = held
//            short_pulse - strobe: short press completed
//            long_pulse  - strobe: long-press threshold reached
//            dbl_pulse   - strobe: double click detected
// Params   : DEB  - cycles of disagreement before the debounced level flips
//            FW   - frame counter width
//            LONG - frames held for a long press (1..2^FW-1)
//            DBL  - double-click window in frames, 0 disables double click
// Revision : 1.0 - initial release
// ============================================================================
module jtframe_btn_decoder #(
    parameter logic [15:0]   DEB  = 16'd1000,
    parameter int unsigned   FW   = 6,
    parameter logic [FW-1:0] LONG = 6'd60,
    parameter logic [FW-1:0] DBL  = 6'd15
) (
    input  logic clk,
    input  logic rst,
    input  logic LVBL,
    input  logic btn_n,
    output logic pressed,
    output logic short_pulse,
    output logic long_pulse,
    output logic dbl_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESS1  = 2'd1,
        ST_WAIT2   = 2'd2,
        ST_WAITREL = 2'd3
    } state_t;

    logic [1:0]    r_sync;
    logic          w_raw;
    logic [15:0]   r_dcnt;
    logic          r_rise;
    logic          r_fall;
    logic          r_last_lvbl;
    logic          r_tick;
    state_t        r_state;
    logic [FW-1:0] r_fcnt;
    logic [FW:0]   w_finc;
    logic [FW-1:0] w_fnext;
    logic          w_long_hit;
    logic          w_dbl_hit;

    // r_sync[1] is the second flop; invert so 1 means pushed.
    assign w_raw = ~r_sync[1];

    // One extra bit keeps the threshold compare from matching on wrap-around.
    assign w_finc     = {1'b0, r_fcnt} + {{FW{1'b0}}, 1'b1};
    assign w_fnext    = (&r_fcnt) ? r_fcnt : w_finc[FW-1:0];
    assign w_long_hit = r_tick && (w_finc == {1'b0, LONG});
    assign w_dbl_hit  = r_tick && (w_finc == {1'b0, DBL});

    // Synchronizer and debouncer. r_rise/r_fall are high during the first
    // cycle of the new debounced level, which is when the FSM acts on them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= 2'b11;
            r_dcnt  <= 16'd0;
            pressed <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], btn_n};
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (w_raw == pressed) begin
                r_dcnt <= 16'd0;
            end else if (r_dcnt == DEB - 16'd1) begin
                pressed <= w_raw;
                r_dcnt  <= 16'd0;
                r_rise  <= w_raw;
                r_fall  <= ~w_raw;
            end else begin
                r_dcnt <= r_dcnt + 16'd1;
            end
        end
    end

    // One-cycle frame tick on the falling edge of LVBL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_lvbl <= 1'b1;
            r_tick      <= 1'b0;
        end else begin
            r_last_lvbl <= LVBL;
            r_tick      <= ~LVBL & r_last_lvbl;
        end
    end

    // Gesture FSM. Debounced edges are checked before the tick so that an
    // edge landing on a tick cycle takes priority over the frame threshold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_fcnt      <= '0;
            short_pulse <= 1'b0;
            long_pulse  <= 1'b0;
            dbl_pulse   <= 1'b0;
        end else begin
            short_pulse <= 1'b0;
            long_pulse  <= 1'b0;
            dbl_pulse   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_rise) begin
                        r_fcnt  <= '0;
                        r_state <= ST_PRESS1;
                    end
                end
                ST_PRESS1: begin
                    if (r_fall) begin
                        if (DBL != '0) begin
                            r_fcnt  <= '0;
                            r_state <= ST_WAIT2;
                        end else begin
                            short_pulse <= 1'b1;
                            r_state     <= ST_IDLE;
                        end
                    end else if (r_tick) begin
                        r_fcnt <= w_fnext;
                        if (w_long_hit) begin
                            long_pulse <= 1'b1;
                            r_state    <= ST_WAITREL;
                        end
                    end
                end
                ST_WAIT2: begin
                    if (r_rise) begin
                        dbl_pulse <= 1'b1;
                        r_state   <= ST_WAITREL;
                    end else if (r_tick) begin
                        r_fcnt <= w_fnext;
                        if (w_dbl_hit) begin
                            short_pulse <= 1'b1;
                            r_state     <= ST_IDLE;
                        end
                    end
                end
                ST_WAITREL: begin
                    if (r_fall) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtframe_btn_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_jtframe_btn_decoder
// Purpose  : Self-checking bench for jtframe_btn_decoder. A behavioural
//            reference (sliding-window debounce, frame-count gestures) is
//            compared with the DUT every cycle; directed scenarios add
//            gesture-level expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtframe_btn_decoder;

    localparam logic [15:0]   DEB   = 16'd4;
    localparam int unsigned   FW    = 6;
    localparam logic [FW-1:0] LONG  = 6'd8;
    localparam logic [FW-1:0] DBL   = 6'd3;
    localparam int            FRAME = 100;
    localparam int            NDEB  = int'(DEB);

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic LVBL  = 1'b1;
    logic btn_n = 1'b1;
    logic pressed;
    logic short_pulse;
    logic long_pulse;
    logic dbl_pulse;

    int n_tests  = 0;
    int n_fail   = 0;
    int n_short  = 0;
    int n_long   = 0;
    int n_dbl    = 0;
    int cyc      = 0;
    int rise_cyc = 0;
    int dbl_gap  = -1;
    int long_gap = -1;
    logic prev_p = 1'b0;

    jtframe_btn_decoder #(
        .DEB  (DEB),
        .FW   (FW),
        .LONG (LONG),
        .DBL  (DBL)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .LVBL        (LVBL),
        .btn_n       (btn_n),
        .pressed     (pressed),
        .short_pulse (short_pulse),
        .long_pulse  (long_pulse),
        .dbl_pulse   (dbl_pulse)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    //   debounce: the level flips once the last DEB synchronized samples
    //   all disagree with it; gestures: frames are ticks elapsed since the
    //   marking event (press accepted or release).
    // ------------------------------------------------------------------
    localparam int G_NONE = 0, G_HELD = 1, G_GAP = 2, G_HOLD_OUT = 3;

    bit bq[$];   // btn_n samples, newest first
    bit rq[$];   // synchronized raw samples, newest first
    bit lq[$];   // LVBL samples, newest first
    bit pq[$];   // model debounced level history, newest first
    bit m_pressed, m_short, m_long, m_dbl;
    int g_phase, ticks, mark;

    task automatic model_reset();
        bq = {1'b1, 1'b1};
        lq = {1'b1, 1'b1};
        pq = {1'b0, 1'b0};
        rq = {};
        for (int i = 0; i < NDEB; i++) rq.push_back(1'b0);
        m_pressed = 1'b0;
        m_short   = 1'b0;
        m_long    = 1'b0;
        m_dbl     = 1'b0;
        g_phase   = G_NONE;
        ticks     = 0;
        mark      = 0;
    endtask

    task automatic model_step();
        bit rise, fall, tick, all_diff;
        rise = pq[0] && !pq[1];
        fall = !pq[0] && pq[1];
        tick = !lq[0] && lq[1];
        m_short = 1'b0;
        m_long  = 1'b0;
        m_dbl   = 1'b0;
        if (tick) ticks++;
        case (g_phase)
            G_NONE: if (rise) begin g_phase = G_HELD; mark = ticks; end
            G_HELD: begin
                if (fall) begin
                    if (DBL == 0) begin m_short = 1'b1; g_phase = G_NONE; end
                    else begin g_phase = G_GAP; mark = ticks; end
                end else if (tick && (ticks - mark == int'(LONG))) begin
                    m_long = 1'b1; g_phase = G_HOLD_OUT;
                end
            end
            G_GAP: begin
                if (rise) begin
                    m_dbl = 1'b1; g_phase = G_HOLD_OUT;
                end else if (tick && (ticks - mark == int'(DBL))) begin
                    m_short = 1'b1; g_phase = G_NONE;
                end
            end
            default: if (fall) g_phase = G_NONE;
        endcase
        rq.push_front(!bq[1]);
        void'(rq.pop_back());
        all_diff = 1'b1;
        for (int i = 0; i < NDEB; i++) if (rq[i] == m_pressed) all_diff = 1'b0;
        if (all_diff) m_pressed = !m_pressed;
        bq.push_front(btn_n);     void'(bq.pop_back());
        lq.push_front(LVBL);      void'(lq.pop_back());
        pq.push_front(m_pressed); void'(pq.pop_back());
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    // Per-cycle comparison and strobe bookkeeping, away from the active edge.
    always @(negedge clk) begin
        cyc++;
        check_eq("cycle_outputs",
                 {28'd0, pressed, short_pulse, long_pulse, dbl_pulse},
                 {28'd0, m_pressed, m_short, m_long, m_dbl});
        if (short_pulse) n_short++;
        if (long_pulse)  n_long++;
        if (dbl_pulse)   n_dbl++;
        if (pressed && !prev_p) rise_cyc = cyc;
        if (dbl_pulse)  dbl_gap  = cyc - rise_cyc;
        if (long_pulse) long_gap = cyc - rise_cyc;
        prev_p = pressed;
    end

    // Frame generator: LVBL low for 10 of every FRAME cycles.
    initial begin
        forever begin
            repeat (FRAME - 10) @(negedge clk);
            LVBL = 1'b0;
            repeat (10) @(negedge clk);
            LVBL = 1'b1;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int s_s, s_l, s_d;
        idle(5);
        #2 rst = 1'b0;
        idle(20);

        // Reset mid-gesture
        s_s = n_short; s_l = n_long; s_d = n_dbl;
        btn_n = 1'b0;
        idle(5 * FRAME);
        #2 rst = 1'b1;
        #1 check_eq("rst_async_outputs", {28'd0, pressed, short_pulse, long_pulse, dbl_pulse}, 32'd0);
        idle(10);
        check_eq("rst_held_outputs", {28'd0, pressed, short_pulse, long_pulse, dbl_pulse}, 32'd0);
        #2 rst = 1'b0;
        idle(5);
        check_eq("rst_lat5_pressed", 32'(pressed), 32'd0);
        idle(1);
        check_eq("rst_lat6_pressed", 32'(pressed), 32'd1);
        idle(5);
        check_eq("rst_no_strobe", 32'((n_short - s_s) + (n_long - s_l) + (n_dbl - s_d)), 32'd0);
        btn_n = 1'b1;
        idle(6 * FRAME);

        // Bounce rejection
        s_s = n_short; s_l = n_long; s_d = n_dbl;
        for (int i = 0; i < 20; i++) begin
            btn_n = ~btn_n;
            idle(2);
            check_eq("bounce_pressed", 32'(pressed), 32'd0);
        end
        btn_n = 1'b1;
        idle(20);
        check_eq("bounce_pressed_end", 32'(pressed), 32'd0);
        check_eq("bounce_no_strobe", 32'((n_short - s_s) + (n_long - s_l) + (n_dbl - s_d)), 32'd0);

        // Short press
        s_s = n_short; s_l = n_long; s_d = n_dbl;
        btn_n = 1'b0;
        idle(5);
        check_eq("short_lat5_pressed", 32'(pressed), 32'd0);
        idle(1);
        check_eq("short_lat6_pressed", 32'(pressed), 32'd1);
        idle(2 * FRAME - 6);
        btn_n = 1'b1;
        idle(6 * FRAME);
        check_eq("short_count", 32'(n_short - s_s), 32'd1);
        check_eq("short_no_long", 32'(n_long - s_l), 32'd0);
        check_eq("short_no_dbl", 32'(n_dbl - s_d), 32'd0);

        // Long press
        s_s = n_short; s_l = n_long; s_d = n_dbl;
        long_gap = -1;
        btn_n = 1'b0;
        idle(12 * FRAME);
        check_eq("long_count", 32'(n_long - s_l), 32'd1);
        check_eq("long_at_8th_tick", 32'((long_gap >= 7 * FRAME) && (long_gap <= 8 * FRAME + 3)), 32'd1);
        btn_n = 1'b1;
        idle(6 * FRAME);
        check_eq("long_no_short", 32'(n_short - s_s), 32'd0);
        check_eq("long_single", 32'(n_long - s_l), 32'd1);
        check_eq("long_no_dbl", 32'(n_dbl - s_d), 32'd0);

        // Double click
        s_s = n_short; s_l = n_long; s_d = n_dbl;
        dbl_gap = -1;
        btn_n = 1'b0; idle(FRAME);
        btn_n = 1'b1; idle(FRAME);
        btn_n = 1'b0; idle(10 * FRAME);
        btn_n = 1'b1; idle(6 * FRAME);
        check_eq("dbl_count", 32'(n_dbl - s_d), 32'd1);
        check_eq("dbl_one_cycle_after_rise", 32'(dbl_gap), 32'd1);
        check_eq("dbl_no_short", 32'(n_short - s_s), 32'd0);
        check_eq("dbl_no_long", 32'(n_long - s_l), 32'd0);

        // Release near the LONG-th tick; d == 0 lands the fall on the tick
        for (int d = -2; d <= 2; d++) begin
            @(negedge LVBL);
            s_s = n_short; s_l = n_long; s_d = n_dbl;
            idle(20);
            btn_n = 1'b0;
            idle(8 * FRAME - 25 + d);
            btn_n = 1'b1;
            idle(6 * FRAME);
            check_eq($sformatf("coll_long_d%0d", d), 32'(n_long - s_l), (d > 0) ? 32'd1 : 32'd0);
            check_eq($sformatf("coll_short_d%0d", d), 32'(n_short - s_s), (d > 0) ? 32'd0 : 32'd1);
            check_eq($sformatf("coll_nodbl_d%0d", d), 32'(n_dbl - s_d), 32'd0);
        end

        // Second press near the DBL expiry; d == 0 lands the rise on it
        for (int d = -2; d <= 2; d++) begin
            @(negedge LVBL);
            s_s = n_short; s_l = n_long; s_d = n_dbl;
            idle(20);
            btn_n = 1'b0; idle(130);
            btn_n = 1'b1; idle(245 + d);
            btn_n = 1'b0; idle(50);
            btn_n = 1'b1; idle(6 * FRAME);
            check_eq($sformatf("win_dbl_d%0d", d), 32'(n_dbl - s_d), (d > 0) ? 32'd0 : 32'd1);
            check_eq($sformatf("win_short_d%0d", d), 32'(n_short - s_s), (d > 0) ? 32'd2 : 32'd0);
            check_eq($sformatf("win_nolong_d%0d", d), 32'(n_long - s_l), 32'd0);
        end

        // Randomized presses with occasional short glitches
        for (int k = 0; k < 20; k++) begin
            int hold, gap;
            hold = int'($urandom_range(1, 1000));
            gap  = int'($urandom_range(1, 400));
            btn_n = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                idle(int'($urandom_range(1, 6)));
                btn_n = 1'b1;
                idle(int'($urandom_range(1, 3)));
                btn_n = 1'b0;
            end
            idle(hold);
            btn_n = 1'b1;
            idle(gap);
        end
        idle(6 * FRAME);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
